// File: rtl/collision_scheduler.sv
// collision_scheduler
//   Shares one rectangle-overlap comparator across an object hitbox table.
//   On Start it captures the player box, then walks the table one object
//   per cycle. Each result lands in HitMask. Hit, HitIndex and a Done pulse
//   are produced once the walk finishes.
//
// Optional build macro:
//   COLLISION_EARLY_EXIT_EN - the scan stops at the first overlapping
//                             object (HitMask then holds only that bit).
//
// Ports
//   Clk, Reset_n        clock, asynchronous active-low reset
//   Start               one-cycle scan request, ignored while a scan runs
//   PlayerX/Y/W/H       player hitbox, sampled only when a scan starts
//   ObjAddr             object-table read address
//   ObjX/Y/W/H          hitbox of the object currently addressed
//   Busy                scan in progress
//   Done                one-cycle pulse when the results below are updated
//   HitMask             per-object overlap flags
//   Hit                 OR of HitMask
//   HitIndex            lowest set bit of HitMask, 0 when there is no hit
module collision_scheduler #(
    parameter int N_OBJ = 8,
    parameter int IDX_W = 3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [9:0]       PlayerX,
    input  logic [9:0]       PlayerY,
    input  logic [9:0]       PlayerW,
    input  logic [9:0]       PlayerH,
    output logic [IDX_W-1:0] ObjAddr,
    input  logic [9:0]       ObjX,
    input  logic [9:0]       ObjY,
    input  logic [9:0]       ObjW,
    input  logic [9:0]       ObjH,
    output logic             Busy,
    output logic             Done,
    output logic [N_OBJ-1:0] HitMask,
    output logic             Hit,
    output logic [IDX_W-1:0] HitIndex
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state, state_next;
    logic [9:0]        px, py, pw, ph;
    logic [10:0]       px_end, py_end, ox_end, oy_end;
    logic              overlap;
    logic              last;
    logic              finish;
    logic [N_OBJ-1:0]  mask_next;
    logic [IDX_W-1:0]  idx_next;

    // Ends are formed in 11 bits so boxes near the 1023 edge cannot wrap.
    // Strict compares make edge-touching boxes miss; empty boxes are
    // rejected explicitly because the strict compares alone would still
    // accept a zero-width box sitting inside the other one.
    always_comb begin
        px_end  = {1'b0, px} + {1'b0, pw};
        py_end  = {1'b0, py} + {1'b0, ph};
        ox_end  = {1'b0, ObjX} + {1'b0, ObjW};
        oy_end  = {1'b0, ObjY} + {1'b0, ObjH};
        overlap = ({1'b0, px} < ox_end) && (px_end > {1'b0, ObjX}) &&
                  ({1'b0, py} < oy_end) && (py_end > {1'b0, ObjY}) &&
                  (pw != 10'd0) && (ph != 10'd0) &&
                  (ObjW != 10'd0) && (ObjH != 10'd0);
    end

    // Mask including the object being compared this cycle, and its lowest
    // set bit, so Hit/HitIndex can be registered on the final edge.
    always_comb begin
        mask_next          = HitMask;
        mask_next[ObjAddr] = overlap;
        idx_next           = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (mask_next[i]) idx_next = IDX_W'(i);
        end
    end

    assign last = (ObjAddr == IDX_W'(N_OBJ - 1));

`ifdef COLLISION_EARLY_EXIT_EN
    assign finish = last || overlap;
`else
    assign finish = last;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start)  state_next = SCAN;
            SCAN:    if (finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            px       <= '0;
            py       <= '0;
            pw       <= '0;
            ph       <= '0;
            ObjAddr  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            HitMask  <= '0;
            Hit      <= 1'b0;
            HitIndex <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        px       <= PlayerX;
                        py       <= PlayerY;
                        pw       <= PlayerW;
                        ph       <= PlayerH;
                        ObjAddr  <= '0;
                        Busy     <= 1'b1;
                        HitMask  <= '0;
                        Hit      <= 1'b0;
                        HitIndex <= '0;
                    end
                end
                SCAN: begin
                    HitMask <= mask_next;
                    if (finish) begin
                        // Address is left on the last object read, so it
                        // saturates at N_OBJ-1 and never runs past an early hit.
                        Done     <= 1'b1;
                        Busy     <= 1'b0;
                        Hit      <= |mask_next;
                        HitIndex <= idx_next;
                    end else begin
                        ObjAddr <= ObjAddr + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
